// File: rtl/irq_controller.sv
// Interrupt controller feeding the CP0 interrupt_source field.
// Synchronises device lines, latches edge/level requests per source,
// picks a fixed-priority winner and runs a signal/claim/complete handshake.
module irq_controller #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic [7:0]         interrupt_source,
  input  logic               claim,
  output logic [2:0]         claim_id,
  output logic               claim_valid,
  input  logic               complete,
  input  logic [2:0]         complete_id
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SIGNAL     = 2'd1,
    IN_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_EDGE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  state_t                                state;
  logic [2:0]                            id;
  logic [NUM_SRC-1:0]                    enable;
  logic [NUM_SRC-1:0]                    edge_mode;
  logic [NUM_SRC-1:0]                    edge_pend;
  logic [NUM_SRC-1:0]                    edge_pend_nxt;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0]   sync_q;
  logic [NUM_SRC-1:0]                    sync_s;
  logic [NUM_SRC-1:0]                    prev_s;
  logic [NUM_SRC-1:0]                    rise;
  logic [NUM_SRC-1:0]                    pending;
  logic [NUM_SRC-1:0]                    elig;
  logic [7:0]                            elig_ext;
  logic [NUM_SRC-1:0]                    clr;
  logic [7:0]                            claim_mask;
  logic [NUM_SRC-1:0]                    wdata_n;
  logic [2:0]                            winner;
  logic                                  found;
  logic                                  unused_wdata;

  assign sync_s       = sync_q[SYNC_STAGES-1];
  assign wdata_n      = cfg_wdata[NUM_SRC-1:0];
  assign unused_wdata = ^cfg_wdata;
  assign claim_id     = id;

  // Input synchroniser chain plus one-cycle history for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_s <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      prev_s <= sync_s;
    end
  end

  // Pending/eligible vectors and edge-pending update; a new edge beats any clear.
  always_comb begin
    rise       = sync_s & ~prev_s;
    pending    = (edge_mode & edge_pend) | (~edge_mode & sync_s);
    elig       = pending & enable;
    elig_ext   = '0;
    elig_ext[NUM_SRC-1:0] = elig;
    claim_mask = '0;
    if (state == SIGNAL && claim) begin
      claim_mask = 8'b1 << id;
    end
    clr = claim_mask[NUM_SRC-1:0];
    if (cfg_we && cfg_addr == ADDR_EDGE) begin
      clr = clr | (edge_mode & ~wdata_n);
    end
    if (cfg_we && cfg_addr == ADDR_PENDING) begin
      clr = clr | wdata_n;
    end
    edge_pend_nxt = (edge_pend & ~clr) | (rise & edge_mode);
  end

  // Fixed priority: lowest eligible index wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (elig[i] && !found) begin
        winner = 3'(i);
        found  = 1'b1;
      end
    end
  end

  // Edge-pending storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      edge_pend <= '0;
    end else begin
      edge_pend <= edge_pend_nxt;
    end
  end

  // Configuration registers; STATUS and PENDING are not stored here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable    <= '0;
      edge_mode <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == ADDR_ENABLE) begin
        enable <= wdata_n;
      end
      if (cfg_addr == ADDR_EDGE) begin
        edge_mode <= wdata_n;
      end
    end
  end

  // Handshake FSM with registered interrupt_source and claim_valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      id               <= '0;
      interrupt_source <= '0;
      claim_valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|elig) begin
            id               <= winner;
            state            <= SIGNAL;
            interrupt_source <= 8'b1 << winner;
            claim_valid      <= 1'b1;
          end
        end
        SIGNAL: begin
          if (claim) begin
            state            <= IN_SERVICE;
            interrupt_source <= '0;
            claim_valid      <= 1'b0;
          end else if (!elig_ext[id]) begin
            state            <= IDLE;
            interrupt_source <= '0;
            claim_valid      <= 1'b0;
          end
        end
        IN_SERVICE: begin
          if (complete && complete_id == id) begin
            state <= IDLE;
          end
        end
        default: begin
          state            <= IDLE;
          interrupt_source <= '0;
          claim_valid      <= 1'b0;
        end
      endcase
    end
  end

  // Register read mux; unused upper bits read zero.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_ENABLE:  cfg_rdata[NUM_SRC-1:0] = enable;
      ADDR_EDGE:    cfg_rdata[NUM_SRC-1:0] = edge_mode;
      ADDR_PENDING: cfg_rdata[NUM_SRC-1:0] = pending;
      ADDR_STATUS: begin
        cfg_rdata[7:6] = state;
        cfg_rdata[2:0] = id;
      end
      default:      cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (NUM_SRC=8, SYNC_STAGES=2).
module tb_irq_controller;

  logic        clock;
  logic        reset;
  logic [7:0]  irq_in;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic [7:0]  interrupt_source;
  logic        claim;
  logic [2:0]  claim_id;
  logic        claim_valid;
  logic        complete;
  logic [2:0]  complete_id;

  int checks;
  int errors;
  logic [31:0] rd;

  irq_controller #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .irq_in           (irq_in),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .cfg_rdata        (cfg_rdata),
    .interrupt_source (interrupt_source),
    .claim            (claim),
    .claim_id         (claim_id),
    .claim_valid      (claim_valid),
    .complete         (complete),
    .complete_id      (complete_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    irq_in      = '0;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_wdata   = '0;
    claim       = 1'b0;
    complete    = 1'b0;
    complete_id = '0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick(1);
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic pulse_claim();
    claim = 1'b1;
    tick(1);
    claim = 1'b0;
  endtask

  task automatic pulse_complete(input logic [2:0] cid);
    complete    = 1'b1;
    complete_id = cid;
    tick(1);
    complete    = 1'b0;
    complete_id = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (interrupt_source !== 8'h00) begin errors++; $display("FAIL reset_irq_src: got %h expected %h", interrupt_source, 8'h00); end
    checks++; if (claim_valid !== 1'b0) begin errors++; $display("FAIL reset_claim_valid: got %b expected %b", claim_valid, 1'b0); end
    checks++; if (claim_id !== 3'd0) begin errors++; $display("FAIL reset_claim_id: got %0d expected %0d", claim_id, 0); end
    cfg_read(2'd0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_enable: got %h expected %h", rd, 32'h0); end
    cfg_read(2'd1, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_edge_mode: got %h expected %h", rd, 32'h0); end
    cfg_write(2'd3, 32'hFFFF_FFFF);
    cfg_read(2'd3, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL status_write_ignored: got %h expected %h", rd, 32'h0); end
    cfg_write(2'd0, 32'hFFFF_FFFF);
    cfg_read(2'd0, rd);
    checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL enable_upper_bits: got %h expected %h", rd, 32'hFF); end
  endtask

  task automatic test_edge_flow();
    do_reset();
    cfg_write(2'd0, 32'h01);
    cfg_write(2'd1, 32'h01);
    irq_in = 8'h01;
    tick(1);
    irq_in = 8'h00;
    tick(1);
    cfg_read(2'd2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_pending_early: got %h expected %h", rd, 32'h0); end
    tick(1);
    cfg_read(2'd2, rd);
    checks++; if (rd !== 32'h01) begin errors++; $display("FAIL edge_pending_set: got %h expected %h", rd, 32'h01); end
    checks++; if (interrupt_source !== 8'h00) begin errors++; $display("FAIL edge_not_yet_signalled: got %h expected %h", interrupt_source, 8'h00); end
    tick(1);
    checks++; if (interrupt_source !== 8'h01) begin errors++; $display("FAIL edge_signal_src: got %h expected %h", interrupt_source, 8'h01); end
    checks++; if (claim_id !== 3'd0 || claim_valid !== 1'b1) begin errors++; $display("FAIL edge_signal_id: got id %0d valid %b expected id 0 valid 1", claim_id, claim_valid); end
    pulse_claim();
    cfg_read(2'd2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_claim_clears: got %h expected %h", rd, 32'h0); end
    cfg_read(2'd3, rd);
    checks++; if (rd !== 32'h80) begin errors++; $display("FAIL edge_in_service: got %h expected %h", rd, 32'h80); end
    checks++; if (interrupt_source !== 8'h00 || claim_valid !== 1'b0) begin errors++; $display("FAIL edge_in_service_out: got src %h valid %b expected 00 0", interrupt_source, claim_valid); end
    pulse_complete(3'd0);
    cfg_read(2'd3, rd);
    checks++; if (rd !== 32'h00) begin errors++; $display("FAIL edge_complete: got %h expected %h", rd, 32'h00); end
  endtask

  task automatic test_level_priority();
    do_reset();
    cfg_write(2'd0, 32'hFF);
    irq_in = 8'h28;
    tick(3);
    checks++; if (claim_id !== 3'd3 || interrupt_source !== 8'h08) begin errors++; $display("FAIL level_first_winner: got id %0d src %h expected id 3 src 08", claim_id, interrupt_source); end
    pulse_claim();
    cfg_read(2'd3, rd);
    checks++; if (rd !== 32'h83) begin errors++; $display("FAIL level_in_service: got %h expected %h", rd, 32'h83); end
    pulse_complete(3'd3);
    cfg_read(2'd3, rd);
    checks++; if (rd !== 32'h03 || interrupt_source !== 8'h00) begin errors++; $display("FAIL level_idle_gap: got status %h src %h expected 03 00", rd, interrupt_source); end
    tick(1);
    checks++; if (claim_id !== 3'd3 || interrupt_source !== 8'h08) begin errors++; $display("FAIL level_resignal: got id %0d src %h expected id 3 src 08", claim_id, interrupt_source); end
    pulse_claim();
    irq_in = 8'h20;
    tick(2);
    pulse_complete(3'd3);
    checks++; if (interrupt_source !== 8'h00) begin errors++; $display("FAIL level_after_drop_idle: got %h expected %h", interrupt_source, 8'h00); end
    tick(1);
    checks++; if (claim_id !== 3'd5 || interrupt_source !== 8'h20) begin errors++; $display("FAIL level_next_winner: got id %0d src %h expected id 5 src 20", claim_id, interrupt_source); end
  endtask

  task automatic test_withdraw();
    do_reset();
    cfg_write(2'd0, 32'hFF);
    irq_in = 8'h04;
    tick(3);
    checks++; if (claim_id !== 3'd2 || interrupt_source !== 8'h04) begin errors++; $display("FAIL withdraw_signal: got id %0d src %h expected id 2 src 04", claim_id, interrupt_source); end
    irq_in = 8'h00;
    tick(2);
    checks++; if (claim_valid !== 1'b1) begin errors++; $display("FAIL withdraw_still_signal: got %b expected %b", claim_valid, 1'b1); end
    tick(1);
    checks++; if (interrupt_source !== 8'h00 || claim_valid !== 1'b0) begin errors++; $display("FAIL withdraw_idle: got src %h valid %b expected 00 0", interrupt_source, claim_valid); end
    pulse_claim();
    cfg_read(2'd3, rd);
    checks++; if (rd !== 32'h02) begin errors++; $display("FAIL withdraw_late_claim: got %h expected %h", rd, 32'h02); end
  endtask

  task automatic test_mismatched_complete();
    do_reset();
    cfg_write(2'd0, 32'hFF);
    irq_in = 8'h10;
    tick(3);
    pulse_claim();
    irq_in = 8'h00;
    checks++; if (claim_id !== 3'd4 || claim_valid !== 1'b0) begin errors++; $display("FAIL mism_in_service_id: got id %0d valid %b expected id 4 valid 0", claim_id, claim_valid); end
    pulse_complete(3'd1);
    cfg_read(2'd3, rd);
    checks++; if (rd !== 32'h84) begin errors++; $display("FAIL mism_ignored: got %h expected %h", rd, 32'h84); end
    pulse_complete(3'd4);
    cfg_read(2'd3, rd);
    checks++; if (rd !== 32'h04) begin errors++; $display("FAIL mism_matching: got %h expected %h", rd, 32'h04); end
  endtask

  task automatic test_edge_collision();
    do_reset();
    cfg_write(2'd1, 32'h40);
    irq_in = 8'h40;
    tick(1);
    irq_in = 8'h00;
    tick(2);
    cfg_read(2'd2, rd);
    checks++; if (rd !== 32'h40) begin errors++; $display("FAIL coll_first_edge: got %h expected %h", rd, 32'h40); end
    cfg_write(2'd2, 32'h40);
    cfg_read(2'd2, rd);
    checks++; if (rd !== 32'h00) begin errors++; $display("FAIL coll_w1c: got %h expected %h", rd, 32'h00); end
    irq_in = 8'h40;
    tick(1);
    irq_in = 8'h00;
    tick(1);
    cfg_write(2'd2, 32'h40);
    cfg_read(2'd2, rd);
    checks++; if (rd !== 32'h40) begin errors++; $display("FAIL coll_set_wins: got %h expected %h", rd, 32'h40); end
    cfg_write(2'd1, 32'h00);
    cfg_write(2'd1, 32'h40);
    cfg_read(2'd2, rd);
    checks++; if (rd !== 32'h00) begin errors++; $display("FAIL coll_mode_clear: got %h expected %h", rd, 32'h00); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg_write(2'd0, 32'hFF);
    irq_in = 8'h02;
    tick(3);
    checks++; if (interrupt_source !== 8'h02) begin errors++; $display("FAIL areset_pre: got %h expected %h", interrupt_source, 8'h02); end
    cfg_addr = 2'd0;
    #1;
    reset = 1'b0;
    #1;
    checks++; if (interrupt_source !== 8'h00 || claim_valid !== 1'b0) begin errors++; $display("FAIL areset_outputs: got src %h valid %b expected 00 0", interrupt_source, claim_valid); end
    checks++; if (cfg_rdata !== 32'h0) begin errors++; $display("FAIL areset_enable: got %h expected %h", cfg_rdata, 32'h0); end
    irq_in = 8'h00;
    tick(1);
    reset = 1'b1;
    tick(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_edge_flow();
    test_level_priority();
    test_withdraw();
    test_mismatched_complete();
    test_edge_collision();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
